kbd_scancode_decoder: RTL and testbench

Consumes the byte stream of the PS/2 bit receiver (one byte plus a one-cycle strobe per valid-parity frame) and assembles Set-2 scan-code sequences into key events. Handles the extended prefix (E0) and break prefix (F0), filters keyboard auto-repeat, and aborts stalled partial sequences by timeout. Sits between the keyboard bit receiver and the game/control logic; outputs one-cycle key-event pulses with a 9-bit key code.

---
 rtl/kbd_pkg.sv | 29 ++
 rtl/kbd_timeout_cntr.sv | 36 +++
 rtl/kbd_scancode_decoder.sv | 139 +++++++++++++
 tb/tb_kbd_scancode_decoder.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 Set-2 scan-code decoder.
// Byte classification lives here so every stage agrees on prefixes.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } kbd_state_e;

  typedef logic [8:0] key_code_t;

  localparam logic [7:0] KBD_EXT = 8'hE0;
  localparam logic [7:0] KBD_BRK = 8'hF0;

  // Keyboard status/ack bytes and the E1 pause prefix carry no key
  function automatic logic is_ignored(input logic [7:0] b);
    logic r;
    r = 1'b0;
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA,
      8'hFE, 8'hFF, 8'hE1: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/kbd_timeout_cntr.sv
// Stall timer for partial scan-code sequences.
// expired pulses on the cycle the count would reach TIMEOUT_CYCLES-1.
module kbd_timeout_cntr #(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 2);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    expired = enable && !clear && (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (clear || !enable || expired) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/kbd_scancode_decoder.sv
// Set-2 scan-code assembler: prefix FSM, auto-repeat filter, and
// registered one-cycle key-event / sequence-error outputs.
module kbd_scancode_decoder
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter bit FILTER_REPEAT  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_new,
  output logic [8:0] key_code,
  output logic       key_make,
  output logic       key_valid,
  output logic       key_held,
  output logic       seq_error
);

  kbd_state_e state_q, state_d;
  key_code_t  held_code_q, held_code_d;
  key_code_t  key_code_q, key_code_d;
  key_code_t  ev_code;
  logic       held_valid_q, held_valid_d;
  logic       key_make_q, key_make_d;
  logic       key_valid_q, key_valid_d;
  logic       seq_error_q, seq_error_d;
  logic       ev, ev_make, is_pfx, expired;

  kbd_timeout_cntr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clear  (din_new),
    .enable (state_q != ST_IDLE),
    .expired(expired)
  );

  always_comb begin
    state_d      = state_q;
    held_code_d  = held_code_q;
    held_valid_d = held_valid_q;
    key_code_d   = key_code_q;
    key_make_d   = key_make_q;
    key_valid_d  = 1'b0;
    seq_error_d  = 1'b0;
    ev           = 1'b0;
    ev_make      = 1'b0;
    ev_code      = '0;
    is_pfx       = (din == KBD_EXT) || (din == KBD_BRK);

    if (din_new) begin
      unique case (state_q)
        ST_IDLE: begin
          unique case (1'b1)
            din == KBD_EXT:  state_d = ST_EXT;
            din == KBD_BRK:  state_d = ST_BRK;
            is_ignored(din): state_d = ST_IDLE;
            default: begin
              ev      = 1'b1;
              ev_make = 1'b1;
              ev_code = {1'b0, din};
            end
          endcase
        end
        ST_EXT: begin
          unique case (1'b1)
            din == KBD_BRK:  state_d = ST_EXT_BRK;
            din == KBD_EXT:  state_d = ST_EXT;
            is_ignored(din): begin
              state_d     = ST_IDLE;
              seq_error_d = 1'b1;
            end
            default: begin
              state_d = ST_IDLE;
              ev      = 1'b1;
              ev_make = 1'b1;
              ev_code = {1'b1, din};
            end
          endcase
        end
        ST_BRK, ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (is_pfx || is_ignored(din)) begin
            seq_error_d = 1'b1;
          end else begin
            ev      = 1'b1;
            ev_code = {state_q == ST_EXT_BRK, din};
          end
        end
      endcase
    end else if (expired) begin
      state_d     = ST_IDLE;
      seq_error_d = 1'b1;
    end

    // A make of the key already held is auto-repeat
    if (ev && !(ev_make && FILTER_REPEAT && held_valid_q &&
                (ev_code == held_code_q))) begin
      key_valid_d = 1'b1;
      key_code_d  = ev_code;
      key_make_d  = ev_make;
      if (ev_make) begin
        held_code_d  = ev_code;
        held_valid_d = 1'b1;
      end else if (ev_code == held_code_q) begin
        held_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      held_code_q  <= '0;
      held_valid_q <= 1'b0;
      key_code_q   <= '0;
      key_make_q   <= 1'b0;
      key_valid_q  <= 1'b0;
      seq_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_code_q  <= held_code_d;
      held_valid_q <= held_valid_d;
      key_code_q   <= key_code_d;
      key_make_q   <= key_make_d;
      key_valid_q  <= key_valid_d;
      seq_error_q  <= seq_error_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_make  = key_make_q;
  assign key_valid = key_valid_q;
  assign key_held  = held_valid_q;
  assign seq_error = seq_error_q;

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
// Bench for kbd_scancode_decoder: directed scenarios plus random byte
// streams against a queue-based sequence model, filtered and unfiltered.
module tb_kbd_scancode_decoder;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_new = 1'b0;

  logic [8:0] a_code, b_code;
  logic       a_make, a_valid, a_held, a_err;
  logic       b_make, b_valid, b_held, b_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  kbd_scancode_decoder #(.TIMEOUT_CYCLES(T), .FILTER_REPEAT(1'b1)) dut (
    .clk(clk), .reset(reset), .din(din), .din_new(din_new),
    .key_code(a_code), .key_make(a_make), .key_valid(a_valid),
    .key_held(a_held), .seq_error(a_err)
  );

  kbd_scancode_decoder #(.TIMEOUT_CYCLES(T), .FILTER_REPEAT(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .din(din), .din_new(din_new),
    .key_code(b_code), .key_make(b_make), .key_valid(b_valid),
    .key_held(b_held), .seq_error(b_err)
  );

  // Reference model: pending prefix bytes kept in a queue
  logic [7:0] pend[$];
  int         age;
  logic [8:0] m_code[2];
  logic [8:0] m_hc[2];
  logic       m_make[2], m_valid[2], m_hv[2];
  logic       m_err;

  function automatic bit ign(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1};
  endfunction

  function automatic void emit(input logic [8:0] c, input logic mk);
    for (int i = 0; i < 2; i++) begin
      if (!(mk && i == 0 && m_hv[i] && m_hc[i] == c)) begin
        m_valid[i] = 1'b1;
        m_code[i]  = c;
        m_make[i]  = mk;
        if (mk) begin
          m_hc[i] = c;
          m_hv[i] = 1'b1;
        end else if (c == m_hc[i]) begin
          m_hv[i] = 1'b0;
        end
      end
    end
  endfunction

  function automatic void model_step(input logic [7:0] b, input logic nb,
                                     input logic rst);
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_code[i] = '0; m_hc[i] = '0; m_make[i] = 1'b0; m_hv[i] = 1'b0;
      end
      pend.delete();
      age = 0;
    end else if (nb) begin
      age = 0;
      if (pend.size() == 0) begin
        if (b == 8'hE0 || b == 8'hF0) pend.push_back(b);
        else if (!ign(b)) emit({1'b0, b}, 1'b1);
      end else if (pend[$] == 8'hE0) begin
        if (b == 8'hF0) pend.push_back(b);
        else if (b == 8'hE0) age = 0;
        else if (ign(b)) begin m_err = 1'b1; pend.delete(); end
        else begin emit({1'b1, b}, 1'b1); pend.delete(); end
      end else begin
        if (b == 8'hE0 || b == 8'hF0 || ign(b)) m_err = 1'b1;
        else emit({pend[0] == 8'hE0, b}, 1'b0);
        pend.delete();
      end
    end else if (pend.size() > 0) begin
      age++;
      if (age == T - 1) begin
        m_err = 1'b1;
        pend.delete();
        age = 0;
      end
    end
  endfunction

  task automatic tick(input logic [7:0] b, input logic nb, input logic rst);
    din = b;
    din_new = nb;
    reset = rst;
    model_step(b, nb, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(8'h00, 1'b0, 1'b1);
    tick(8'h1C, 1'b1, 1'b1);
    n_cmp++;
    if ({a_code, a_make, a_valid, a_held, a_err} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_a: got %h %b%b%b%b want 000 0000",
               a_code, a_make, a_valid, a_held, a_err);
    end
    n_cmp++;
    if ({b_code, b_make, b_valid, b_held, b_err} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_b: got %h %b%b%b%b want 000 0000",
               b_code, b_make, b_valid, b_held, b_err);
    end
    tick(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_make_break();
    tick(8'h1C, 1'b1, 1'b0);
    n_cmp++;
    if ({a_valid, a_code, a_make, a_held} !== {1'b1, 9'h01C, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL make_1c: got v=%b c=%h m=%b h=%b want v=1 c=01c m=1 h=1",
               a_valid, a_code, a_make, a_held);
    end
    tick(8'h00, 1'b0, 1'b0);
    n_cmp++;
    if ({a_valid, a_held} !== 2'b01) begin
      n_bad++;
      $display("FAIL make_pulse: got v=%b h=%b want v=0 h=1", a_valid, a_held);
    end
    tick(8'hF0, 1'b1, 1'b0);
    n_cmp++;
    if (a_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL brk_prefix: got v=%b want 0", a_valid);
    end
    tick(8'h1C, 1'b1, 1'b0);
    n_cmp++;
    if ({a_valid, a_code, a_make, a_held} !== {1'b1, 9'h01C, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL break_1c: got v=%b c=%h m=%b h=%b want v=1 c=01c m=0 h=0",
               a_valid, a_code, a_make, a_held);
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq[5];
    int         pulses;
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick(seq[i], 1'b1, 1'b0);
      if (a_valid) pulses++;
      if (i == 1) begin
        n_cmp++;
        if ({a_valid, a_code, a_make} !== {1'b1, 9'h175, 1'b1}) begin
          n_bad++;
          $display("FAIL ext_make: got v=%b c=%h m=%b want v=1 c=175 m=1",
                   a_valid, a_code, a_make);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if ({a_valid, a_code, a_make} !== {1'b1, 9'h175, 1'b0}) begin
          n_bad++;
          $display("FAIL ext_break: got v=%b c=%h m=%b want v=1 c=175 m=0",
                   a_valid, a_code, a_make);
        end
      end
    end
    n_cmp++;
    if (pulses != 2) begin
      n_bad++;
      $display("FAIL ext_pulses: got %0d want 2", pulses);
    end
  endtask

  task automatic test_repeat_filter();
    logic [7:0] seq[5];
    int         pa, pb;
    seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    pa = 0;
    pb = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) tick(seq[i], 1'b1, 1'b0);
      else tick(8'h00, 1'b0, 1'b0);
      if (a_valid) pa++;
      if (b_valid) pb++;
    end
    n_cmp++;
    if (pa != 2) begin
      n_bad++;
      $display("FAIL repeat_filtered: got %0d pulses want 2", pa);
    end
    n_cmp++;
    if (pb != 4) begin
      n_bad++;
      $display("FAIL repeat_unfiltered: got %0d pulses want 4", pb);
    end
  endtask

  task automatic test_timeout();
    int err_at, errs, bad;
    tick(8'hE0, 1'b1, 1'b0);
    err_at = -1;
    errs = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(8'h00, 1'b0, 1'b0);
      if (a_err) begin
        errs++;
        if (err_at < 0) err_at = k;
      end
    end
    n_cmp++;
    if (err_at != T - 1 || errs != 1) begin
      n_bad++;
      $display("FAIL timeout: got err at idle %0d (%0d pulses) want %0d (1)",
               err_at, errs, T - 1);
    end
    tick(8'h1C, 1'b1, 1'b0);
    n_cmp++;
    if ({a_valid, a_code, a_make} !== {1'b1, 9'h01C, 1'b1}) begin
      n_bad++;
      $display("FAIL after_timeout: got v=%b c=%h m=%b want v=1 c=01c m=1",
               a_valid, a_code, a_make);
    end
    tick(8'hE0, 1'b1, 1'b0);
    for (int k = 1; k < T - 1; k++) tick(8'h00, 1'b0, 1'b0);
    tick(8'h75, 1'b1, 1'b0);
    n_cmp++;
    if ({a_err, a_valid, a_code} !== {1'b0, 1'b1, 9'h175}) begin
      n_bad++;
      $display("FAIL byte_wins: got e=%b v=%b c=%h want e=0 v=1 c=175",
               a_err, a_valid, a_code);
    end
    bad = 0;
    tick(8'hE0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick(8'h00, 1'b0, 1'b0);
      if (a_err) bad++;
    end
    tick(8'hE0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick(8'h00, 1'b0, 1'b0);
      if (a_err) bad++;
    end
    tick(8'h6B, 1'b1, 1'b0);
    n_cmp++;
    if (bad != 0 || {a_valid, a_code} !== {1'b1, 9'h16B}) begin
      n_bad++;
      $display("FAIL e0_restart: got errs=%0d v=%b c=%h want 0 1 16b",
               bad, a_valid, a_code);
    end
  endtask

  task automatic test_ignored();
    int hits;
    hits = 0;
    tick(8'hAA, 1'b1, 1'b0);
    if (a_valid || a_err) hits++;
    tick(8'hFA, 1'b1, 1'b0);
    if (a_valid || a_err) hits++;
    n_cmp++;
    if (hits != 0) begin
      n_bad++;
      $display("FAIL ignored_idle: got %0d outputs want 0", hits);
    end
    tick(8'hF0, 1'b1, 1'b0);
    tick(8'hE0, 1'b1, 1'b0);
    n_cmp++;
    if ({a_err, a_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL f0_e0: got e=%b v=%b want e=1 v=0", a_err, a_valid);
    end
    hits = 0;
    for (int k = 0; k < T + 4; k++) begin
      tick(8'h00, 1'b0, 1'b0);
      if (a_err) hits++;
    end
    tick(8'hE0, 1'b1, 1'b0);
    tick(8'hAA, 1'b1, 1'b0);
    n_cmp++;
    if (hits != 0 || a_err !== 1'b1) begin
      n_bad++;
      $display("FAIL e0_aa: got idle errs=%0d e=%b want 0 1", hits, a_err);
    end
    tick(8'h2A, 1'b1, 1'b0);
    n_cmp++;
    if ({a_valid, a_code, a_make} !== {1'b1, 9'h02A, 1'b1}) begin
      n_bad++;
      $display("FAIL after_err: got v=%b c=%h m=%b want v=1 c=02a m=1",
               a_valid, a_code, a_make);
    end
  endtask

  task automatic test_reset_mid_seq();
    tick(8'hF0, 1'b1, 1'b0);
    tick(8'h1C, 1'b1, 1'b1);
    n_cmp++;
    if ({a_code, a_make, a_valid, a_held, a_err,
         b_code, b_make, b_valid, b_held, b_err} !== 26'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got a=%h%b%b%b%b b=%h%b%b%b%b want zeros",
               a_code, a_make, a_valid, a_held, a_err,
               b_code, b_make, b_valid, b_held, b_err);
    end
    tick(8'h1C, 1'b1, 1'b0);
    n_cmp++;
    if ({a_valid, a_code, a_make, a_held} !== {1'b1, 9'h01C, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL post_reset: got v=%b c=%h m=%b h=%b want v=1 c=01c m=1 h=1",
               a_valid, a_code, a_make, a_held);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[10];
    seq = '{8'hE0, 8'hF0, 8'h6B, 8'h33, 8'hF0, 8'h33,
            8'hE0, 8'h75, 8'hF0, 8'h1C};
    for (int i = 0; i < 10; i++) begin
      tick(seq[i], 1'b1, 1'b0);
      n_cmp++;
      if ({a_valid, a_code, a_make, a_held, a_err} !==
          {m_valid[0], m_code[0], m_make[0], m_hv[0], m_err}) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got v=%b c=%h m=%b h=%b e=%b want v=%b c=%h m=%b h=%b e=%b",
                 i, a_valid, a_code, a_make, a_held, a_err,
                 m_valid[0], m_code[0], m_make[0], m_hv[0], m_err);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[4];
    logic [7:0] ig[7];
    logic [7:0] b;
    logic       nb, rst;
    int         r, quiet;
    pool = '{8'h1C, 8'h75, 8'h6B, 8'h2A};
    ig = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1};
    quiet = 0;
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = ig[$urandom_range(0, 6)];
        5, 6, 7: b = pool[$urandom_range(0, 3)];
        default: b = 8'($urandom);
      endcase
      if (quiet == 0 && $urandom_range(0, 29) == 0) quiet = $urandom_range(5, 25);
      nb = (quiet == 0) && ($urandom_range(0, 9) < 6);
      if (quiet > 0) quiet--;
      rst = ($urandom_range(0, 199) == 0);
      tick(b, nb, rst);
      n_cmp++;
      if ({a_valid, a_code, a_make, a_held, a_err} !==
          {m_valid[0], m_code[0], m_make[0], m_hv[0], m_err}) begin
        n_bad++;
        $display("FAIL rand_a[%0d]: got v=%b c=%h m=%b h=%b e=%b want v=%b c=%h m=%b h=%b e=%b",
                 c, a_valid, a_code, a_make, a_held, a_err,
                 m_valid[0], m_code[0], m_make[0], m_hv[0], m_err);
      end
      n_cmp++;
      if ({b_valid, b_code, b_make, b_held, b_err} !==
          {m_valid[1], m_code[1], m_make[1], m_hv[1], m_err}) begin
        n_bad++;
        $display("FAIL rand_b[%0d]: got v=%b c=%h m=%b h=%b e=%b want v=%b c=%h m=%b h=%b e=%b",
                 c, b_valid, b_code, b_make, b_held, b_err,
                 m_valid[1], m_code[1], m_make[1], m_hv[1], m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_repeat_filter();
    test_timeout();
    test_ignored();
    test_reset_mid_seq();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
